rf_wport_arbiter: RTL and testbench

//   Arbitrates the single register-file write port between the in-order WB stage
//   and the long-latency unit (mul/div) writeback. Grants at most one writer per

---
 rtl/rf_wport_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter.
// Picks one writer per cycle between the in-order WB stage and the long-latency
// unit. WB normally has priority, but LU is forced a grant after STARVE_MAX
// consecutive WB wins while LU was waiting. The winner's write and its single
// retire record leave through one register stage.
module rf_wport_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wb_valid,
    input  logic                           wb_wen,
    input  logic [ADDR_W-1:0]              wb_waddr,
    input  logic [DATA_W-1:0]              wb_wdata,
    input  logic [31:0]                    wb_pc,
    output logic                           wb_ready,
    input  logic                           lu_valid,
    input  logic [ADDR_W-1:0]              lu_waddr,
    input  logic [DATA_W-1:0]              lu_wdata,
    input  logic [31:0]                    lu_pc,
    output logic                           lu_ready,
    output logic                           rf_wen,
    output logic [ADDR_W-1:0]              rf_waddr,
    output logic [DATA_W-1:0]              rf_wdata,
    output logic                           retire_valid,
    output logic [ADDR_W+DATA_W+32:0]      retire_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {PRI_WB, PRI_LU} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt, cnt_nxt, cnt_inc;
    logic              grant;
    logic              sel_wen;
    logic [ADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0] sel_wdata;
    logic [31:0]       sel_pc;
    logic              eff_wen;

    assign cnt_inc = starve_cnt + 1'b1;

    // Priority state and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PRI_WB;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= cnt_nxt;
        end
    end

    // Grant decision and next priority state; nothing is granted during reset.
    always_comb begin
        wb_ready  = 1'b0;
        lu_ready  = 1'b0;
        state_nxt = state;
        cnt_nxt   = starve_cnt;
        if (!rst) begin
            case (state)
                PRI_WB: begin
                    if (wb_valid) begin
                        wb_ready = 1'b1;
                        if (lu_valid) begin
                            // LU lost again: count it, hand priority over at the limit.
                            cnt_nxt = cnt_inc;
                            if (cnt_inc == CNT_W'(STARVE_MAX))
                                state_nxt = PRI_LU;
                        end else begin
                            cnt_nxt = '0;
                        end
                    end else begin
                        lu_ready = lu_valid;
                        cnt_nxt  = '0;
                    end
                end
                PRI_LU: begin
                    // LU holds its request while starved, so this normally exits at once.
                    if (lu_valid) begin
                        lu_ready  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = PRI_WB;
                    end else begin
                        wb_ready = wb_valid;
                    end
                end
                default: state_nxt = PRI_WB;
            endcase
        end
    end

    // Winner payload mux; LU results always write.
    always_comb begin
        grant     = wb_ready | lu_ready;
        sel_wen   = lu_ready ? 1'b1     : wb_wen;
        sel_waddr = lu_ready ? lu_waddr : wb_waddr;
        sel_wdata = lu_ready ? lu_wdata : wb_wdata;
        sel_pc    = lu_ready ? lu_pc    : wb_pc;
        eff_wen   = grant & sel_wen & (sel_waddr != '0);
    end

    // Output register stage: write bus plus one retire record per grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            retire_valid <= 1'b0;
            retire_data  <= '0;
        end else begin
            rf_wen       <= eff_wen;
            retire_valid <= grant;
            if (grant) begin
                rf_waddr    <= sel_waddr;
                rf_wdata    <= sel_wdata;
                retire_data <= {eff_wen, sel_waddr, sel_wdata, sel_pc};
            end else begin
                retire_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Randomized + directed bench for rf_wport_arbiter against a request-level model.
module tb_rf_wport_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int STARVE_MAX = 4;
    localparam int RET_W      = 1 + ADDR_W + DATA_W + 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid, wb_wen, wb_ready;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic [31:0]       wb_pc;
    logic              lu_valid, lu_ready;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_wdata;
    logic [31:0]       lu_pc;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              retire_valid;
    logic [RET_W-1:0]  retire_data;

    rf_wport_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .wb_pc(wb_pc), .wb_ready(wb_ready),
        .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .lu_pc(lu_pc), .lu_ready(lu_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_valid(retire_valid), .retire_data(retire_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          wen;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } req_t;

    req_t        wb, lu;
    int          streak;      // consecutive WB wins over a waiting LU
    bit          owed;        // LU must win the next contested cycle
    logic [4:0]  last_a;
    logic [31:0] last_d;
    int          n_chk, n_fail;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_wb(input bit wen, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        wb.v = 1; wb.wen = wen; wb.a = a; wb.d = d; wb.pc = pc;
    endtask

    task automatic set_lu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        lu.v = 1; lu.wen = 1; lu.a = a; lu.d = d; lu.pc = pc;
    endtask

    // One clock: drive pending requests, check grants, then check the registered result.
    task automatic step(input bit r);
        bit              ewr, elr, ewen;
        logic [RET_W-1:0] eret;
        req_t            win;
        @(negedge clk);
        rst      = r;
        wb_valid = wb.v; wb_wen = wb.wen; wb_waddr = wb.a; wb_wdata = wb.d; wb_pc = wb.pc;
        lu_valid = lu.v; lu_waddr = lu.a; lu_wdata = lu.d; lu_pc = lu.pc;
        #1;
        ewr = 0; elr = 0;
        if (!r) begin
            if (wb.v && lu.v) begin
                if (owed) elr = 1; else ewr = 1;
            end else if (wb.v) ewr = 1;
            else if (lu.v) elr = 1;
        end
        chk("wb_ready", wb_ready, ewr);
        chk("lu_ready", lu_ready, elr);
        if (r) begin
            streak = 0; owed = 0;
        end else if (ewr && lu.v) begin
            streak++;
            if (streak == STARVE_MAX) owed = 1;
        end else begin
            streak = 0; owed = 0;
        end
        win  = elr ? lu : wb;
        ewen = (ewr || elr) && win.wen && (win.a != 0);
        eret = '0;
        if (r) begin
            last_a = '0; last_d = '0;
        end else if (ewr || elr) begin
            last_a = win.a; last_d = win.d;
            eret   = {ewen, win.a, win.d, win.pc};
        end
        @(posedge clk);
        #1;
        chk("rf_wen", rf_wen, ewen);
        chk("rf_waddr", rf_waddr, last_a);
        chk("rf_wdata", rf_wdata, last_d);
        chk("retire_valid", retire_valid, (ewr || elr));
        chk("retire_data", retire_data, eret);
        if (ewr || r) wb.v = 0;
        if (elr || r) lu.v = 0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; streak = 0; owed = 0;
        last_a = '0; last_d = '0;
        wb = '{0, 0, 0, 0, 0};
        lu = '{0, 0, 0, 0, 0};
        rst = 1;
        wb_valid = 0; wb_wen = 0; wb_waddr = 0; wb_wdata = 0; wb_pc = 0;
        lu_valid = 0; lu_waddr = 0; lu_wdata = 0; lu_pc = 0;

        // Reset with requests present: no ready, outputs cleared.
        set_wb(1, 5'd3, 32'hdead, 32'h40);
        set_lu(5'd4, 32'hbeef, 32'h44);
        step(1);
        step(1);

        // WB alone.
        set_wb(1, 5'd5, 32'h1234, 32'h100);
        step(0);

        // Both held: WB x4 then LU.
        set_lu(5'd7, 32'h7777, 32'h200);
        for (int i = 0; i < 5; i++) begin
            set_wb(1, 5'(8 + i), 32'h1000 + i, 32'h300 + 4 * i);
            step(0);
        end
        wb.v = 0;
        chk("starve_cleared", {30'd0, owed, streak[0]}, 32'd0);

        // Write to x0 and a non-writing WB instruction.
        set_wb(1, 5'd0, 32'h55, 32'h400);
        step(0);
        set_wb(0, 5'd9, 32'h66, 32'h404);
        step(0);

        // LU alone three cycles.
        for (int i = 0; i < 3; i++) begin
            set_lu(5'(20 + i), 32'hA000 + i, 32'h500 + 4 * i);
            step(0);
        end

        // Reset in the middle of a starvation run, then a contested cycle.
        set_lu(5'd11, 32'h1111, 32'h600);
        for (int i = 0; i < 3; i++) begin
            set_wb(1, 5'(12 + i), 32'h2000 + i, 32'h700 + 4 * i);
            step(0);
        end
        set_wb(1, 5'd15, 32'h2003, 32'h70c);
        step(1);
        set_wb(1, 5'd16, 32'h3000, 32'h800);
        set_lu(5'd17, 32'h3001, 32'h804);
        step(0);
        step(0);

        // Idle.
        for (int i = 0; i < 10; i++) step(0);

        // Random traffic honouring hold-until-granted, with rare resets.
        for (int i = 0; i < 3000; i++) begin
            if (!wb.v && ($urandom_range(0, 3) != 0))
                set_wb(1'($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                       $urandom, $urandom);
            if (!lu.v && ($urandom_range(0, 2) == 0))
                set_lu(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
            step($urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
